// File: rtl/arb3_pkg.sv
// arb3_pkg: shared types and constants for the three-way active-low arbiter
package arb3_pkg;
  localparam int NREQ = 3;
  localparam int ARB3_IDX_W = 2;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
endpackage

// File: rtl/arb3_rr_pick.sv
// arb3_rr_pick: rotating priority encoder, order last+1, last+2, last (mod 3)
//   req  : active-high requests
//   last : previous owner
//   hit  : any request present
//   win  : selected requester
module arb3_rr_pick
  import arb3_pkg::*;
(
  input  logic [NREQ-1:0]       req,
  input  logic [ARB3_IDX_W-1:0] last,
  output logic                  hit,
  output logic [ARB3_IDX_W-1:0] win
);
  logic [ARB3_IDX_W-1:0] p0, p1, p2;
  // last==3 never occurs; it falls through to the 0,1,2 order
  assign p0 = (last == 2'd0) ? 2'd1 : (last == 2'd1) ? 2'd2 : 2'd0;
  assign p1 = (p0 == 2'd0) ? 2'd1 : (p0 == 2'd1) ? 2'd2 : 2'd0;
  assign p2 = (p1 == 2'd0) ? 2'd1 : (p1 == 2'd1) ? 2'd2 : 2'd0;
  assign hit = |req;
  assign win = req[p0] ? p0 : req[p1] ? p1 : p2;
endmodule

// File: rtl/arb3_lowreq.sv
// arb3_lowreq: round-robin arbiter for three active-low requesters with one idle cycle between owners
//   C      : clock, rising edge
//   CLR_N  : asynchronous active-low reset
//   REQ_N  : active-low level requests
//   GNT_N  : registered active-low grants, one-cold or all high
//   GNT_ID : current owner, valid while BUSY
//   BUSY   : resource granted
//   TOUT   : one-cycle pulse when a grant is revoked by timeout
// Optional grant timeout enabled by defining ARB3_TIMEOUT_EN (limit TIMEOUT, >= 2).
module arb3_lowreq
  import arb3_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  C,
  input  logic                  CLR_N,
  input  logic [NREQ-1:0]       REQ_N,
  output logic [NREQ-1:0]       GNT_N,
  output logic [ARB3_IDX_W-1:0] GNT_ID,
  output logic                  BUSY,
  output logic                  TOUT
);
`ifdef ARB3_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t                state;
  logic [ARB3_IDX_W-1:0] last, win;
  logic [NREQ-1:0]       mask, req;
  logic [CW-1:0]         cnt;
  logic                  hit, rel, tmo;
  assign req = ~REQ_N & ~mask;
  arb3_rr_pick u_pick (.req(req), .last(last), .hit(hit), .win(win));
  assign rel = REQ_N[GNT_ID];
  // a release on the timeout edge wins, so tmo requires the owner still requesting
  assign tmo = TO_EN && !rel && (cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state  <= IDLE;
      GNT_N  <= '1;
      GNT_ID <= '0;
      BUSY   <= 1'b0;
      TOUT   <= 1'b0;
      last   <= 2'd2;
      mask   <= '0;
      cnt    <= '0;
    end else begin
      TOUT <= 1'b0;
      mask <= mask & ~REQ_N;
      case (state)
        GRANT: begin
          cnt <= cnt + 1'b1;
          if (rel || tmo) begin
            GNT_N <= '1;
            BUSY  <= 1'b0;
            last  <= GNT_ID;
            state <= GAP;
          end
          if (tmo) begin
            TOUT         <= 1'b1;
            mask[GNT_ID] <= 1'b1;
          end
        end
        default: begin
          if (hit) begin
            GNT_N  <= ~(3'b001 << win);
            GNT_ID <= win;
            BUSY   <= 1'b1;
            cnt    <= '0;
            state  <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_arb3_lowreq.sv
// tb_arb3_lowreq: directed and randomized checks of arb3_lowreq against a behavioural model
module tb_arb3_lowreq;
  localparam int TIMEOUT = 4;
`ifdef ARB3_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic       C, CLR_N;
  logic [2:0] REQ_N;
  logic [2:0] GNT_N;
  logic [1:0] GNT_ID;
  logic       BUSY, TOUT;
  int n_cmp = 0;
  int n_bad = 0;
  arb3_lowreq #(.TIMEOUT(TIMEOUT)) dut (
    .C(C), .CLR_N(CLR_N), .REQ_N(REQ_N),
    .GNT_N(GNT_N), .GNT_ID(GNT_ID), .BUSY(BUSY), .TOUT(TOUT)
  );
  initial C = 1'b0;
  always #5 C = ~C;
  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: owner (-1 = none), previous owner, per-requester mask, cycles held
  int       m_own, m_last, m_len;
  bit [2:0] m_mask;
  bit       m_tout;
  logic [2:0] r;
  always @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      m_own = -1; m_last = 2; m_mask = '0; m_len = 0; m_tout = 0;
    end else begin
      r = REQ_N;
      m_tout = 0;
      if (m_own >= 0) begin
        m_len++;
        if (r[m_own]) begin
          m_last = m_own; m_own = -1;
        end else if (TO_EN && m_len == TIMEOUT) begin
          m_tout = 1; m_mask[m_own] = 1; m_last = m_own; m_own = -1;
        end
      end else begin
        for (int k = 1; k <= 3; k++) begin
          int i;
          i = (m_last + k) % 3;
          if (m_own < 0 && !r[i] && !m_mask[i]) begin
            m_own = i; m_len = 0;
          end
        end
      end
      for (int i = 0; i < 3; i++) if (r[i]) m_mask[i] = 0;
    end
  end
  always @(negedge C) begin
    cmp("model_gnt_n", int'(GNT_N), (m_own >= 0) ? int'(3'b111 ^ (3'b001 << m_own)) : 7);
    cmp("model_busy", int'(BUSY), (m_own >= 0) ? 1 : 0);
    cmp("model_tout", int'(TOUT), int'(m_tout));
    if (m_own >= 0) cmp("model_gnt_id", int'(GNT_ID), m_own);
  end
  task automatic tick();
    @(posedge C);
    #1;
  endtask
  int exp_ord[5] = '{0, 1, 2, 0, 1};
  initial begin
    CLR_N = 1'b0;
    REQ_N = 3'b000;
    repeat (3) tick();
    cmp("reset_gnt_n", int'(GNT_N), 7);
    cmp("reset_busy", int'(BUSY), 0);
    cmp("reset_tout", int'(TOUT), 0);
    cmp("reset_gnt_id", int'(GNT_ID), 0);
    CLR_N = 1'b1;
    tick();
    for (int g = 0; g < 5; g++) begin
      cmp("fair_gnt_n", int'(GNT_N), int'(3'b111 ^ (3'b001 << exp_ord[g])));
      cmp("fair_gnt_id", int'(GNT_ID), exp_ord[g]);
      repeat (3) tick();
      cmp("fair_hold", int'(GNT_N), int'(3'b111 ^ (3'b001 << exp_ord[g])));
      REQ_N = 3'(1 << exp_ord[g]);
      tick();
      cmp("fair_gap", int'(GNT_N), 7);
      cmp("fair_gap_tout", int'(TOUT), 0);
      REQ_N = 3'b000;
      tick();
    end
    REQ_N = 3'b111;
    repeat (2) tick();
    REQ_N = 3'b110;
    tick();
    cmp("single_gnt_n", int'(GNT_N), 6);
    repeat (4) tick();
    REQ_N = 3'b111;
    tick();
    cmp("single_rel_gnt_n", int'(GNT_N), 7);
    cmp("single_rel_busy", int'(BUSY), 0);
    tick();
    cmp("single_idle_busy", int'(BUSY), 0);
    REQ_N = 3'b011;
    tick();
    cmp("hand_own2", int'(GNT_ID), 2);
    REQ_N = 3'b001;
    repeat (2) tick();
    REQ_N = 3'b101;
    tick();
    cmp("hand_gap", int'(GNT_N), 7);
    tick();
    cmp("hand_gnt_n", int'(GNT_N), 5);
    cmp("hand_gnt_id", int'(GNT_ID), 1);
    REQ_N = 3'b111;
    repeat (2) tick();
    REQ_N = 3'b101;
    tick();
    cmp("to_gnt_n", int'(GNT_N), 5);
`ifdef ARB3_TIMEOUT_EN
    repeat (3) begin
      tick();
      cmp("to_hold", int'(GNT_N), 5);
      cmp("to_hold_tout", int'(TOUT), 0);
    end
    tick();
    cmp("to_revoke_gnt_n", int'(GNT_N), 7);
    cmp("to_pulse", int'(TOUT), 1);
    tick();
    cmp("to_pulse_end", int'(TOUT), 0);
    cmp("to_masked", int'(GNT_N), 7);
    tick();
    cmp("to_masked2", int'(GNT_N), 7);
    REQ_N = 3'b111;
    tick();
    REQ_N = 3'b101;
    tick();
    cmp("to_regrant", int'(GNT_N), 5);
`else
    repeat (10) tick();
    cmp("hold_forever", int'(GNT_N), 5);
    cmp("hold_tout", int'(TOUT), 0);
`endif
    REQ_N = 3'b111;
    repeat (2) tick();
    REQ_N = 3'b110;
    tick();
    cmp("rst_mid_own0", int'(GNT_N), 6);
    tick();
    #2 CLR_N = 1'b0;
    #1;
    cmp("rst_mid_gnt_n", int'(GNT_N), 7);
    cmp("rst_mid_busy", int'(BUSY), 0);
    REQ_N = 3'b011;
    #2 CLR_N = 1'b1;
    tick();
    cmp("rst_after_gnt_n", int'(GNT_N), 3);
    cmp("rst_after_gnt_id", int'(GNT_ID), 2);
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        #1 CLR_N = 1'b0;
        #1 CLR_N = 1'b1;
      end
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 5) == 0) REQ_N[i] = ~REQ_N[i];
    end
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/arb3_lowreq.md
# arb3_lowreq

Round-robin arbiter sharing one resource between three requesters with active-low request lines. The "any request pending" term is a three-input OR of inverted inputs, the same function as our OR3B3 primitive. Sits between the requester ports and the shared resource and drives one active-low grant per requester. It grants one requester at a time, holds the grant until that requester releases, and inserts one idle cycle between owners.

## Interface
- `TIMEOUT`, default 255: maximum grant length in cycles. Legal range is ≥2. Used only with `ARB3_TIMEOUT_EN`.
- `C` input, 1 bit: clock, rising edge.
- `CLR_N` input, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `REQ_N` input, 3 bits: requests, active-low, level. Bit i belongs to requester i.
- `GNT_N` output, 3 bits: grants, active-low, registered, one-cold or all high.
- `GNT_ID` output, 2 bits: index of the current owner. Valid only while `BUSY`=1.
- `BUSY` output, 1 bit: resource granted.
- `TOUT` output, 1 bit: one-cycle pulse when a grant is revoked by timeout.

## Operation
- Internal request vector: `req[i] = ~REQ_N[i] & ~mask[i]`. `any_req = |req`.
- Pointer `LAST` (2 bits) holds the previous owner. Priority order is LAST+1, LAST+2, LAST, all mod 3.
- States:
  - IDLE: if `any_req`, latch winner `w`, drive `GNT_N[w]`=0, set `GNT_ID`=w and `BUSY`=1, go to GRANT. Otherwise stay.
  - GRANT: while `REQ_N[w]`=0, hold. When `REQ_N[w]`=1 is sampled: `GNT_N`=111, `BUSY`=0, `LAST`=w, go to GAP.
  - GAP: exactly one cycle with all grants high. If `any_req`, arbitrate as in IDLE using the updated `LAST` and go to GRANT. Otherwise go to IDLE.
- Other requesters changing `REQ_N` during GRANT have no effect on the current owner.
- A requester that drops `REQ_N` before it is granted loses its request. Nothing is queued.
- Reset values: `GNT_N`=111, `GNT_ID`=00, `BUSY`=0, `TOUT`=0, state IDLE, `LAST`=2 (requester 0 first), `mask`=000, timeout counter 0.
- Asynchronous reset mid-grant forces all outputs to reset values immediately, without waiting for a clock edge.

## Timing
- Request-to-grant latency from IDLE: `REQ_N` sampled low at edge t, so `GNT_N` is low after edge t.
- Release-to-regrant: owner release sampled at edge t, so all grants are high for cycle t..t+1 and the next grant appears after edge t+1.
- All outputs are registered. There is no combinational path from `REQ_N` to any output.

## Configuration
- `ARB3_TIMEOUT_EN` defined:
  - Counter of width $clog2(TIMEOUT+1) clears on entry to GRANT and increments each GRANT cycle.
  - At the edge where count == TIMEOUT-1 and the owner is still requesting, the grant is revoked. `GNT_N[w]` goes high and the block enters GAP. `TOUT`=1 for that one cycle and `mask[w]`=1. `LAST` is set to w.
  - `mask[i]` clears on any edge where `REQ_N[i]`=1 is sampled.
  - If release and timeout occur on the same edge, it is treated as a normal release: no `TOUT`, no mask.
- `ARB3_TIMEOUT_EN` undefined: no counter, `mask` is constant 000, `TOUT` is tied 0, and a grant is held indefinitely.

## Structure
- Package `arb3_pkg`:
  - state enum {IDLE, GRANT, GAP}.
  - constant `NREQ`=3.
  - `ARB3_IDX_W`=2.
- Sub-module `arb3_rr_pick`: combinational rotating priority encoder. Inputs are `req[2:0]` and `LAST`. Outputs are `hit` and `win[1:0]`. It is used in both IDLE and GAP.

## Test plan
- Reset: hold `CLR_N`=0 with `REQ_N`=000. Expect `GNT_N`=111, `BUSY`=0, `TOUT`=0. On deassertion with `REQ_N`=000, expect the first grant to go to requester 0 (`GNT_N`=110, `GNT_ID`=0).
- Single requester: `REQ_N`=110 at edge 0 gives `GNT_N`=110 after edge 0. Drive `REQ_N`=111 at edge 5: `GNT_N`=111 and `BUSY`=0 after edge 5, then state IDLE after edge 6.
- Fairness: hold all `REQ_N` low, with each owner releasing for one cycle after 4 grant cycles. Expect grant order 0,1,2,0,1. Each grant lasts 4 cycles with exactly one all-high GAP cycle between grants.
- Handoff: requester 2 is the owner and requester 1 is low. Requester 2 releases at edge t. Expect `GNT_N`=111 during t..t+1 and `GNT_N`=101, `GNT_ID`=1 after edge t+1.
- Timeout (`ARB3_TIMEOUT_EN`, `TIMEOUT`=4): `REQ_N`=101 held. Expect `GNT_N[1]` low for exactly 4 cycles, then a `TOUT` pulse of 1 cycle and no regrant to requester 1 while `REQ_N[1]` stays low. After one cycle of `REQ_N[1]`=1 followed by low again, expect requester 1 to be granted.
- Reset mid-grant: owner 0 holds the grant and `CLR_N` falls between edges. Expect `GNT_N`=111 and `BUSY`=0 before the next edge. After release from reset with `REQ_N`=011, expect requester 2 to be granted.
